// File: rtl/imgpipe_pkg.sv
// Shared definitions for the image pipeline: pixel width, default frame size,
// window-generator state encoding and a width helper.
package imgpipe_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;

    typedef enum logic {
        WIN_FILL = 1'b0,
        WIN_RUN  = 1'b1
    } win_state_e;

    // Counter width for a 0..n-1 range, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buf.sv
// One image line of storage: combinational read and registered write at the
// same address, so a read in the write cycle returns the old (previous-line) value.
module line_buf
    import imgpipe_pkg::*;
#(
    parameter  int DEPTH = DEF_IMG_W,
    parameter  int DW    = PIX_W,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // NOTE: the storage array has no reset; every location is rewritten before
    // it can reach a valid window, so clearing it would only cost logic.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen3x3.sv
// Raster stream to 3x3 neighbourhood generator feeding the Sobel stage.
// Optional WINGEN_SOF_EN adds in_sof to resynchronise framing at any pixel.
module window_gen3x3
    import imgpipe_pkg::*;
#(
    parameter  int IMG_W = DEF_IMG_W,
    parameter  int IMG_H = DEF_IMG_H,
    parameter  int DW    = PIX_W,
    localparam int XW    = clog2_min1(IMG_W),
    localparam int YW    = clog2_min1(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
`ifdef WINGEN_SOF_EN
    input  logic          in_sof,
`endif
    input  logic [DW-1:0] in_pixel,
    output logic          win_valid,
    output logic [DW-1:0] p00,
    output logic [DW-1:0] p01,
    output logic [DW-1:0] p02,
    output logic [DW-1:0] p10,
    output logic [DW-1:0] p11,
    output logic [DW-1:0] p12,
    output logic [DW-1:0] p20,
    output logic [DW-1:0] p21,
    output logic [DW-1:0] p22,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          frame_done
);

    typedef logic [2:0][2:0][DW-1:0] window_t;

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    win_state_e    state_q, state_d;
    window_t       win_q, win_d;
    logic          wv_q, wv_d;
    logic [XW-1:0] wx_q, wx_d;
    logic [YW-1:0] wy_q, wy_d;
    logic          fd_q, fd_d;

    logic          sof;
    logic [XW-1:0] lb_addr;
    logic [DW-1:0] lb0_rd, lb1_rd;

`ifdef WINGEN_SOF_EN
    assign sof = in_valid & in_sof;
`else
    assign sof = 1'b0;
`endif

    // A start-of-frame pixel is stored as column 0 whatever the counter says.
    assign lb_addr = sof ? '0 : col_q;

    line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (lb_addr),
        .wdata_i (in_pixel),
        .rdata_o (lb1_rd)
    );

    line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
        .clk     (clk),
        .we_i    (in_valid),
        .addr_i  (lb_addr),
        .wdata_i (lb1_rd),
        .rdata_o (lb0_rd)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        win_d   = win_q;
        wv_d    = 1'b0;
        wx_d    = wx_q;
        wy_d    = wy_q;
        fd_d    = 1'b0;

        if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = in_pixel;

            if (sof) begin
                col_d   = XW'(1);
                row_d   = '0;
                state_d = WIN_FILL;
            end else begin
                wv_d = (state_q == WIN_RUN) && (col_q >= XW'(2));
                if (wv_d) begin
                    wx_d = col_q - XW'(1);
                    wy_d = row_q - YW'(1);
                end
                fd_d = (col_q == XW'(IMG_W - 1)) && (row_q == YW'(IMG_H - 1));

                if (col_q == XW'(IMG_W - 1)) begin
                    col_d = '0;
                    if (row_q == YW'(IMG_H - 1)) begin
                        row_d   = '0;
                        state_d = WIN_FILL;
                    end else begin
                        row_d = row_q + YW'(1);
                        if (row_q == YW'(1)) begin
                            state_d = WIN_RUN;
                        end
                    end
                end else begin
                    col_d = col_q + XW'(1);
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= WIN_FILL;
            win_q   <= '0;
            wv_q    <= 1'b0;
            wx_q    <= '0;
            wy_q    <= '0;
            fd_q    <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            state_q <= state_d;
            win_q   <= win_d;
            wv_q    <= wv_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            fd_q    <= fd_d;
        end
    end

    assign win_valid  = wv_q;
    assign p00        = win_q[0][0];
    assign p01        = win_q[0][1];
    assign p02        = win_q[0][2];
    assign p10        = win_q[1][0];
    assign p11        = win_q[1][1];
    assign p12        = win_q[1][2];
    assign p20        = win_q[2][0];
    assign p21        = win_q[2][1];
    assign p22        = win_q[2][2];
    assign win_x      = wx_q;
    assign win_y      = wy_q;
    assign frame_done = fd_q;

endmodule
